// File: rtl/sa2_launcher_pkg.sv
// Shared types and sizes for the 2x2 systolic-array launcher.
package sa2_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_A  = 16;
  localparam int NUM_B  = 9;
  localparam int NUM_C  = 4;
  localparam int NUM_IN = NUM_A + NUM_B;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/sa2_launcher_if.sv
// Connection between the launcher and the systolic_array_2_by_2.
// The launcher is the master: it drives the operands and the run request.
interface sa2_launcher_if;
  import sa2_pkg::*;

  logic                      active_sa2;
  logic [NUM_A*DATA_W-1:0]   a_bus;
  logic [NUM_B*DATA_W-1:0]   b_bus;
  logic                      done_sa2;
  logic [NUM_C*DATA_W-1:0]   c_bus;

  modport master (
    output active_sa2, a_bus, b_bus,
    input  done_sa2, c_bus
  );

  modport slave (
    input  active_sa2, a_bus, b_bus,
    output done_sa2, c_bus
  );

endinterface

// File: rtl/sa2_launcher.sv
// Loads a 4x4 tile and 3x3 filter from a byte stream, runs one array job
// under a watchdog, then streams the four result bytes out.
module sa2_launcher
  import sa2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  sa2_launcher_if.master      arr,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                err
);

  localparam logic [4:0] LAST_IN   = 5'(NUM_IN - 1);
  localparam logic [4:0] LAST_OUT  = 5'(NUM_C - 1);
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [4:0]        idx;
  logic [7:0]        wdog;
  logic [DATA_W-1:0] opnd [NUM_IN];
  logic [DATA_W-1:0] res  [NUM_C];

  // Job sequencer: operand load, watchdog-guarded run, result drain.
  // NOTE: non-blocking assignments so every register here sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      idx   <= '0;
      wdog  <= '0;
      // NOTE: operand/result files are reset because they drive the array
      // and the output port directly and must read zero after reset.
      for (int i = 0; i < NUM_IN; i++) opnd[i] <= '0;
      for (int c = 0; c < NUM_C; c++)  res[c]  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            opnd[idx] <= in_data;
            if (idx == LAST_IN) begin
              idx   <= '0;
              wdog  <= '0;
              state <= RUN;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        RUN: begin
          wdog <= wdog + 8'd1;
          // Completion takes priority over a coincident timeout.
          if (arr.done_sa2) begin
            for (int c = 0; c < NUM_C; c++) res[c] <= arr.c_bus[c*DATA_W +: DATA_W];
            idx   <= '0;
            state <= DRAIN;
          end else if (wdog == WDOG_LAST) begin
            state <= FAULT;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == LAST_OUT) begin
              idx   <= '0;
              state <= LOAD;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready       = (state == LOAD);
  assign arr.active_sa2 = (state == RUN);
  assign out_valid      = (state == DRAIN);
  assign err            = (state == FAULT);
  assign out_data       = (state == DRAIN) ? res[idx[1:0]] : '0;

  // Flatten the operand file onto the array buses, a-tile first.
  for (genvar i = 0; i < NUM_A; i++) begin : g_a_bus
    assign arr.a_bus[i*DATA_W +: DATA_W] = opnd[i];
  end
  for (genvar j = 0; j < NUM_B; j++) begin : g_b_bus
    assign arr.b_bus[j*DATA_W +: DATA_W] = opnd[NUM_A + j];
  end

endmodule

// File: tb/tb_sa2_launcher.sv
// Directed bench for sa2_launcher with a short watchdog (TIMEOUT_CYCLES=8).
module tb_sa2_launcher;
  import sa2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       err;

  int checks = 0;
  int errors = 0;
  int act;

  sa2_launcher_if arr_if ();

  sa2_launcher #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .arr       (arr_if),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads 25 bytes base, base+1, ...; optionally with in_valid every other cycle.
  task automatic load_job(input logic [7:0] base, input bit toggle);
    int taken = 0;
    int cyc = 0;
    logic [127:0] ea;
    logic [71:0]  eb;
    while (taken < 25 && cyc < 100) begin
      in_valid = !toggle || (cyc % 2 == 0);
      in_data  = in_valid ? base + 8'(taken) : 8'hEE;
      if (in_valid && in_ready) taken++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("load_count", 128'(taken), 128'd25);
    for (int i = 0; i < 16; i++) ea[i*8 +: 8] = base + 8'(i);
    for (int j = 0; j < 9; j++)  eb[j*8 +: 8] = base + 8'(16 + j);
    check("a_bus", arr_if.a_bus, ea);
    check("b_bus", 128'(arr_if.b_bus), 128'(eb));
    check("run_active", 128'(arr_if.active_sa2), 128'd1);
    check("run_in_ready", 128'(in_ready), 128'd0);
  endtask

  // Spends n RUN cycles; done_sa2 is high during cycle done_at (0 = never).
  task automatic run_cycles(input int n, input int done_at, input logic [31:0] c, output int a);
    a = 0;
    for (int k = 1; k <= n; k++) begin
      arr_if.done_sa2 = (k == done_at);
      arr_if.c_bus    = c;
      if (arr_if.active_sa2) a++;
      tick();
    end
    arr_if.done_sa2 = 1'b0;
  endtask

  task automatic drain(input logic [31:0] c);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 128'(out_valid), 128'd1);
      check("drain_data", 128'(out_data), 128'(c[i*8 +: 8]));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("post_drain_in_ready", 128'(in_ready), 128'd1);
    check("post_drain_out_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    arr_if.done_sa2 = 1'b0;
    arr_if.c_bus    = '0;

    // Reset values
    #12;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_active", 128'(arr_if.active_sa2), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_a_bus", arr_if.a_bus, 128'd0);
    rst = 1'b1;
    tick();

    // 1: back-to-back load, done on the 3rd RUN cycle
    load_job(8'd1, 1'b0);
    check("t1_a_first", 128'(arr_if.a_bus[7:0]), 128'd1);
    check("t1_a_last", 128'(arr_if.a_bus[127:120]), 128'd16);
    check("t1_b_last", 128'(arr_if.b_bus[71:64]), 128'd25);
    run_cycles(3, 3, 32'h44332211, act);
    check("t1_active_cycles", 128'(act), 128'd3);
    check("t1_active_off", 128'(arr_if.active_sa2), 128'd0);
    drain(32'h44332211);

    // 2 + 6: gappy load, stall mid-drain with in_valid/done_sa2 noise
    load_job(8'd100, 1'b1);
    run_cycles(1, 1, 32'h44332211, act);
    check("t2_active_cycles", 128'(act), 128'd1);
    check("t2_c11", 128'(out_data), 128'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1;
      in_data = 8'h77;
      arr_if.done_sa2 = 1'b1;
      arr_if.c_bus = 32'hFFFFFFFF;
      tick();
      check("t2_stall_data", 128'(out_data), 128'h22);
      check("t2_stall_valid", 128'(out_valid), 128'd1);
      check("t2_stall_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    arr_if.done_sa2 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("t2_resume_data", 128'(out_data), 128'(8'h11 * (i + 1)));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("t2_in_ready", 128'(in_ready), 128'd1);
    check("t2_a_kept", 128'(arr_if.a_bus[7:0]), 128'd100);

    // 4: done_sa2 on exactly the timeout edge
    load_job(8'h40, 1'b0);
    run_cycles(8, 8, 32'hA1B2C3D4, act);
    check("t4_active_cycles", 128'(act), 128'd8);
    check("t4_err", 128'(err), 128'd0);
    drain(32'hA1B2C3D4);

    // 3: timeout with done_sa2 never asserted
    load_job(8'h60, 1'b0);
    run_cycles(7, 0, 32'h0, act);
    check("t3_err_early", 128'(err), 128'd0);
    check("t3_active_early", 128'(arr_if.active_sa2), 128'd1);
    run_cycles(1, 0, 32'h0, act);
    check("t3_err", 128'(err), 128'd1);
    check("t3_active", 128'(arr_if.active_sa2), 128'd0);
    check("t3_out_valid", 128'(out_valid), 128'd0);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1;
      in_data = 8'h99;
      arr_if.done_sa2 = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    arr_if.done_sa2 = 1'b0;
    check("t3_in_ready", 128'(in_ready), 128'd0);
    check("t3_err_sticky", 128'(err), 128'd1);
    check("t3_a_kept", 128'(arr_if.a_bus[7:0]), 128'h60);

    // 5: reset clears the fault, then reset mid-load, then a full job
    rst = 1'b0;
    #1;
    check("t5_err_cleared", 128'(err), 128'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'(200 + i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_a_zero", arr_if.a_bus, 128'd0);
    check("t5_b_zero", 128'(arr_if.b_bus), 128'd0);
    check("t5_in_ready", 128'(in_ready), 128'd1);
    #2;
    rst = 1'b1;
    tick();
    load_job(8'h30, 1'b0);
    run_cycles(2, 2, 32'h04030201, act);
    check("t5_active_cycles", 128'(act), 128'd2);
    drain(32'h04030201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa2_launcher.md
# sa2_launcher

- Initiator and sequencer for one `systolic_array_2_by_2` job:
  - Collects the 4×4 data tile and the 3×3 filter from an 8-bit byte stream.
  - Holds them stable on the array's operand inputs and asserts `active_sa2` until `done_sa2`.
  - Captures the four results and streams them out as bytes.
- Sits between the tile-fetch logic and the array. The array's operand, result and handshake ports connect directly to this block.

## Interface

Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `TIMEOUT_CYCLES`, 64: maximum RUN cycles allowed before `done_sa2` is declared missing. Legal range 2..255.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset. 0 = reset asserted.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte. Order is a11..a44 row-major, then b11..b33 row-major (25 bytes).
- `in_ready` out 1: block accepts `in_data`.
- `active_sa2` out 1: run request to the array.
- `a_bus` out 128: a11 at [7:0], a12 at [15:8], …, a44 at [127:120].
- `b_bus` out 72: b11 at [7:0], …, b33 at [71:64].
- `done_sa2` in 1: completion flag from the array.
- `c_bus` in 32: c11 at [7:0], c12 at [15:8], c21 at [23:16], c22 at [31:24].
- `out_valid` out 1: result byte valid.
- `out_data` out 8: result byte, order c11, c12, c21, c22.
- `out_ready` in 1: downstream accepts `out_data`.
- `err` out 1: timeout fault, sticky.

## Operation

State machine states: LOAD, RUN, DRAIN, FAULT. Reset enters LOAD.

LOAD
- `in_ready` = 1.
- A byte transfers on a rising edge where `in_valid` && `in_ready`. It is written into operand slot `idx` (0..24), and `idx` increments.
- Acceptance of slot 24 → RUN. At the same time `idx` clears and the watchdog clears.

RUN
- `active_sa2` = 1 and `in_ready` = 0. `a_bus` and `b_bus` are frozen.
- The watchdog increments every RUN cycle.
- `done_sa2` sampled 1:
  - capture `c_bus` into `res[0..3]`;
  - go to DRAIN;
  - clear `idx`.
- Watchdog reaching `TIMEOUT_CYCLES`-1 with `done_sa2` = 0 → FAULT.
- `done_sa2` and timeout on the same edge: done wins, go to DRAIN.

DRAIN
- `out_valid` = 1 and `out_data` = `res[idx]`.
- `idx` advances on `out_valid` && `out_ready`.
- Transfer of `idx` 3 → LOAD with `idx` = 0.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.

FAULT
- `err` = 1. `in_ready`, `active_sa2` and `out_valid` are all 0.
- Exit is by reset only.

General rules
- `in_valid` outside LOAD is ignored. No byte is consumed.
- `done_sa2` outside RUN is ignored.
- Values are 8-bit unsigned and are passed through unmodified. This block does no arithmetic.
- Operand registers update only in LOAD. They keep the previous job's values until overwritten.

## Timing

Reset values (while `rst` = 0):
- state = LOAD, `idx` = 0, watchdog = 0;
- all operand and result registers = 0;
- `in_ready` = 1, `active_sa2` = 0, `out_valid` = 0, `out_data` = 0, `err` = 0.

Output timing
- All outputs are registered-state decodes. No combinational path from any input to any output.

Latencies
- Last input byte accepted at edge N → `active_sa2` = 1 from edge N.
- `done_sa2` sampled at edge M → `active_sa2` = 0 and `out_valid` = 1 from edge M, with `out_data` = c11.
- Last result accepted at edge K → `in_ready` = 1 from edge K.

Throughput
- Job time = 25 input transfers + RUN cycles + 4 output transfers.
- Best case with a 1-cycle RUN: 30 cycles per job.

Reset mid-operation
- Reset in any state discards the partial load, captured results and the fault. The block returns to reset values immediately.
- The array has its own reset and is not reset by this block.

## Structure

Package `sa2_pkg` holds:
- state enum (`LOAD`, `RUN`, `DRAIN`, `FAULT`);
- `DATA_W`=8, `NUM_A`=16, `NUM_B`=9, `NUM_C`=4, `NUM_IN`=25.

Implementation
- One module.
- Operand storage is a 25-entry × 8-bit register file, flattened onto `a_bus`/`b_bus`.
- The watchdog is an 8-bit counter inline. No sub-module is needed.

## Test plan

1. Load bytes 1..25 back-to-back; `done_sa2` pulses on the 3rd RUN cycle with `c_bus` = 0x44332211.
   - `a_bus`[7:0] = 1 and `a_bus`[127:120] = 16; `b_bus`[71:64] = 25.
   - `active_sa2` is high for exactly 3 cycles.
   - `out_data` sequence is 0x11, 0x22, 0x33, 0x44, then `in_ready` = 1.
2. `in_valid` toggling every other cycle during LOAD, and `out_ready` low for 5 cycles mid-DRAIN:
   - exactly 25 bytes are taken;
   - `out_data` holds 0x22 through the stall;
   - no byte is duplicated or dropped.
3. `TIMEOUT_CYCLES` = 8 with `done_sa2` never asserted:
   - `err` = 1 after 8 RUN cycles and `active_sa2` = 0;
   - `in_valid` is then ignored until reset.
4. `done_sa2` asserted on exactly the timeout edge → DRAIN entered and `err` stays 0.
5. Reset asserted after 10 input bytes, then a full job loaded:
   - results are correct;
   - `a_bus` holds only the new values.
6. `in_valid` and `done_sa2` pulses while in DRAIN → no state or `idx` change, and `res` is unaltered.
